fifo_rr_read_arbiter: RTL and testbench

- Round-robin read scheduler that drains NUM_REQ register-file FIFOs into one valid/ready output stream.
- Each FIFO's registered read port has one-cycle latency. The block sequences exactly one read strobe at a time, captures the returned word, and tags it with its source index.
- Sits between a bank of per-channel FIFOs and a single shared downstream consumer.

---
 rtl/fifo_rr_read_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_rr_read_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_read_arbiter.sv
// Round-robin read scheduler: drains a bank of one-cycle-latency FIFOs into a
// single valid/ready stream, one word in flight at a time, tagged with its source.
module fifo_rr_read_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int SRC_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            fifo_empty,
  output logic [NUM_REQ-1:0]            fifo_read,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_read_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_WIDTH-1:0]          out_src
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SRC_WIDTH-1:0]   grant_q, grant_d;
  logic [SRC_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [SRC_WIDTH-1:0]   out_src_q, out_src_d;

  logic [NUM_REQ-1:0]     req, above, req_hi;
  logic                   hi_any, lo_any, pick_any;
  logic [SRC_WIDTH-1:0]   hi_idx, lo_idx, pick_idx;
  logic                   take_grant;
  logic [DATA_WIDTH-1:0]  rd_words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rd_words[i] = fifo_read_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: lowest requester above last_grant, else lowest overall.
  always_comb begin
    req    = ~fifo_empty;
    above  = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      above[SRC_WIDTH'(i)] = (SRC_WIDTH'(i) > last_grant_q);
    end
    req_hi = req & above;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_hi[SRC_WIDTH'(i)]) begin
        hi_any = 1'b1;
        hi_idx = SRC_WIDTH'(i);
      end
      if (req[SRC_WIDTH'(i)]) begin
        lo_any = 1'b1;
        lo_idx = SRC_WIDTH'(i);
      end
    end
    pick_any = hi_any | lo_any;
    pick_idx = hi_any ? hi_idx : lo_idx;
  end

  // Handshake: a word transfers on any cycle with out_valid & out_ready; while
  // out_ready is low the word and its tag are held and no new strobe is issued.
  assign take_grant = reset_n && pick_any &&
                      ((state_q == ST_IDLE) || ((state_q == ST_VALID) && out_ready));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_WIDTH'(NUM_REQ - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_VALID;
      ST_VALID: if (out_ready) state_d = pick_any ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_read    = '0;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    if (take_grant) begin
      fifo_read[pick_idx] = 1'b1;
      grant_d             = pick_idx;
      last_grant_d        = pick_idx;
    end
    // The FIFO's read register updated on the strobe edge, so capture now.
    if (state_q == ST_FETCH) begin
      out_data_d  = rd_words[grant_q];
      out_src_d   = grant_q;
      out_valid_d = 1'b1;
    end
    if ((state_q == ST_VALID) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// Bench for fifo_rr_read_arbiter: FIFO bank model, transaction-level arbitration
// model with an expected-word queue, directed scenarios then random traffic.
module tb_fifo_rr_read_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int W  = SW + DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [N-1:0]    fifo_empty;
  logic [N-1:0]    fifo_read;
  logic [N*DW-1:0] fifo_read_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;

  fifo_rr_read_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .fifo_read_data(fifo_read_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src)
  );

  // FIFO bank model
  logic [DW-1:0] fmem [N][64];
  int            head [N];
  int            tail [N];
  logic [DW-1:0] rd_reg [N];

  // reference model and scoreboard
  int            m_last;
  int            m_stage;   // 0 nothing held, 1 word in flight, 2 word presented
  logic [W-1:0]  exp_q[$];
  int            cyc;
  int            n_checks;
  int            n_fail;

  // observation logs
  int            st_src[$];
  int            st_cyc[$];
  logic [W-1:0]  acc_w[$];
  int            acc_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_fifo();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (head[i] == tail[i]);
      fifo_read_data[i*DW +: DW] = rd_reg[i];
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] d);
    fmem[i][tail[i] % 64] = d;
    tail[i]++;
    sync_fifo();
  endtask

  function automatic int rr_pick(input int last);
    for (int d = 1; d <= N; d++) begin
      int idx;
      idx = (last + d) % N;
      if (tail[idx] != head[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic clear_logs();
    st_src.delete();
    st_cyc.delete();
    acc_w.delete();
    acc_cyc.delete();
  endtask

  // driver: one clock cycle, checking DUT outputs against the model at negedge
  task automatic step();
    logic [N-1:0] e_rd;
    logic [N-1:0] rd_seen;
    int g;
    @(negedge clk);
    g    = -1;
    e_rd = '0;
    if (reset_n && (m_stage == 0 || (m_stage == 2 && out_ready))) begin
      g = rr_pick(m_last);
      if (g >= 0) e_rd[g] = 1'b1;
    end
    chk("fifo_read", 32'(fifo_read), 32'(e_rd));
    chk("out_valid", 32'(out_valid), 32'(m_stage == 2));
    if (m_stage == 2) chk("out_word", 32'({out_src, out_data}), 32'(exp_q[0]));
    rd_seen = fifo_read;
    for (int i = 0; i < N; i++) begin
      if (rd_seen[i]) begin
        st_src.push_back(i);
        st_cyc.push_back(cyc);
      end
    end
    if (reset_n && out_valid && out_ready) begin
      acc_w.push_back({out_src, out_data});
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!reset_n) begin
      m_stage = 0;
      m_last  = N - 1;
      exp_q.delete();
    end else begin
      if (m_stage == 2 && out_ready) begin
        void'(exp_q.pop_front());
        m_stage = 0;
      end else if (m_stage == 1) begin
        m_stage = 2;
      end
      if (g >= 0) begin
        exp_q.push_back({SW'(g), fmem[g][head[g] % 64]});
        m_last  = g;
        m_stage = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rd_seen[i] && head[i] != tail[i]) begin
        rd_reg[i] = fmem[i][head[i] % 64];
        head[i]++;
      end
    end
    sync_fifo();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    m_last   = N - 1;
    m_stage  = 0;
    for (int i = 0; i < N; i++) begin
      head[i]   = 0;
      tail[i]   = 0;
      rd_reg[i] = '0;
    end
    reset_n   = 1'b0;
    out_ready = 1'b0;
    sync_fifo();

    // reset then idle
    step();
    step();
    chk("rst_fifo_read", 32'(fifo_read), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    reset_n = 1'b1;

    // single FIFO
    out_ready = 1'b1;
    clear_logs();
    push(2, 8'hA1);
    push(2, 8'hA2);
    run(12);
    chk("single_strobes", 32'(st_src.size()), 32'd2);
    chk("single_src0", 32'(st_src[0]), 32'd2);
    chk("single_src1", 32'(st_src[1]), 32'd2);
    chk("single_strobe_gap", 32'(st_cyc[1] - st_cyc[0]), 32'd2);
    chk("single_word0", 32'(acc_w[0]), 32'({2'd2, 8'hA1}));
    chk("single_word1", 32'(acc_w[1]), 32'({2'd2, 8'hA2}));
    chk("single_latency", 32'(acc_cyc[0] - st_cyc[0]), 32'd2);
    chk("single_second", 32'(acc_cyc[1] - st_cyc[0]), 32'd4);
    chk("single_idle_valid", 32'(out_valid), 32'h0);
    chk("single_idle_read", 32'(fifo_read), 32'h0);

    // round-robin over all four FIFOs
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) push(i, DW'(8'h10 + i));
    for (int i = 0; i < N; i++) push(i, DW'(8'h20 + i));
    run(24);
    chk("rr_count", 32'(acc_w.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      logic [DW-1:0] ed;
      ed = (j < 4) ? DW'(8'h10 + j) : DW'(8'h20 + j - 4);
      chk("rr_word", 32'(acc_w[j]), 32'({SW'(j % 4), ed}));
    end

    // backpressure
    clear_logs();
    out_ready = 1'b0;
    push(1, 8'h55);
    push(1, 8'h66);
    k = 0;
    while (!out_valid && k < 10) begin
      step();
      k++;
    end
    chk("bp_rise", 32'(out_valid), 32'h1);
    for (int j = 0; j < 5; j++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_hold_data", 32'(out_data), 32'h55);
      chk("bp_no_read", 32'(fifo_read), 32'h0);
    end
    chk("bp_strobes", 32'(st_src.size()), 32'd1);
    out_ready = 1'b1;
    run(8);
    chk("bp_word0", 32'(acc_w[0]), 32'({2'd1, 8'h55}));
    chk("bp_word1", 32'(acc_w[1]), 32'({2'd1, 8'h66}));
    chk("bp_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);

    // wrap and skip
    do_reset();
    clear_logs();
    push(1, 8'h31);
    push(1, 8'h32);
    push(3, 8'h33);
    run(12);
    chk("wrap_count", 32'(st_src.size()), 32'd3);
    chk("wrap_g0", 32'(st_src[0]), 32'd1);
    chk("wrap_g1", 32'(st_src[1]), 32'd3);
    chk("wrap_g2", 32'(st_src[2]), 32'd1);

    // reset during FETCH
    do_reset();
    push(0, 8'hB0);
    push(0, 8'hB1);
    push(0, 8'hB2);
    step();
    chk("midrst_strobe", 32'(st_src[st_src.size() - 1]), 32'd0);
    reset_n = 1'b0;
    step();
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_read", 32'(fifo_read), 32'h0);
    reset_n = 1'b1;
    clear_logs();
    run(10);
    chk("midrst_first_src", 32'(st_src[0]), 32'd0);
    chk("midrst_word0", 32'(acc_w[0]), 32'({2'd0, 8'hB1}));
    chk("midrst_word1", 32'(acc_w[1]), 32'({2'd0, 8'hB2}));

    // random traffic
    for (int j = 0; j < 800; j++) begin
      int f;
      if ($urandom_range(0, 2) == 0) begin
        f = int'($urandom_range(0, N - 1));
        if (tail[f] - head[f] < 60) push(f, DW'($urandom_range(0, 255)));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset_n   = ($urandom_range(0, 199) != 0);
      step();
    end
    reset_n   = 1'b1;
    out_ready = 1'b1;
    k = 0;
    while (k < 600 && (m_stage != 0 || rr_pick(m_last) >= 0)) begin
      step();
      k++;
    end
    chk("drain_done", 32'(m_stage == 0 && rr_pick(m_last) < 0), 32'h1);
    chk("drain_idle", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
